fir_coef_sequencer: RTL and testbench
=====================================

Name: fir_coef_sequencer

Overview:
Controller in front of the FIR core. The FIR shares one x_n bus between sample data and coefficient reload words. This block owns that bus and a register bank holding one full coefficient image (NUM_WORDS words, each carrying 3 packed 2-bit taps). It sequences the FIR's reset setup window, coefficient reload bursts (set_coeffs), and the sample stream (tvalid), and arbitrates so that sample and coefficient traffic never overlap.

Parameters:
X_N_SIZE, 8, width of sample bus and FIR x_n.
NUM_WORDS, 7, coefficient words per reload burst (21 taps / 3 taps per word).
ADDR_W, 3, bank address width; must satisfy 2^ADDR_W >= NUM_WORDS.
SETUP_CYCLES, 4, cycles after reset before any FIR traffic.
LEAD_CYCLES, 1, cycles set_coeffs is high before word 0 is presented.
DRAIN_CYCLES, 2, idle cycles after a burst before samples resume.

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high
cfg_we  in  1  bank write strobe
cfg_addr  in  ADDR_W  bank write address
cfg_wdata  in  6  coefficient word; [5:4]=tap 3k, [3:2]=tap 3k+1, [1:0]=tap 3k+2
cfg_commit  in  1  single-cycle request to reload the FIR from the bank
cfg_busy  out  1  high while a commit is pending or a burst is in progress
cfg_done  out  1  single-cycle pulse on completion of a burst
cfg_wr_err  out  1  single-cycle pulse when a write is rejected
s_valid  in  1  upstream sample valid
s_data  in  X_N_SIZE  upstream sample
s_ready  out  1  upstream sample ready
fir_x_n  out  X_N_SIZE  FIR x_n bus
fir_tvalid  out  1  FIR s_axis_fir_tvalid
fir_set_coeffs  out  1  FIR s_set_coeffs

Behaviour:
- Reset: state=WAIT_SETUP, setup counter=0, pending=0; all outputs 0. Bank contents are not reset; after reset they are undefined until written.
- States: WAIT_SETUP, PASS, LEAD, LOAD, DRAIN.
- WAIT_SETUP: counts SETUP_CYCLES cycles, then enters PASS. s_ready=0. A cfg_commit in this state is latched into pending.
- PASS:
  - s_ready = !pending (combinational).
  - fir_tvalid = s_valid & s_ready.
  - fir_x_n = s_data when s_ready=1, else 0.
  - If pending: clear pending and go to LEAD on the next edge.
- LEAD: fir_set_coeffs=1, fir_x_n=0. Lasts LEAD_CYCLES cycles, then goes to LOAD with word index=0.
- LOAD:
  - fir_set_coeffs=1; fir_x_n = {0, bank[idx]}, zero-extended to X_N_SIZE.
  - idx increments every cycle.
  - After the cycle with idx=NUM_WORDS-1, go to DRAIN. LOAD lasts exactly NUM_WORDS cycles.
- DRAIN:
  - fir_set_coeffs=0, fir_x_n=0.
  - Lasts DRAIN_CYCLES cycles, then returns to PASS.
  - cfg_done pulses in the last DRAIN cycle.
- fir_tvalid=0 and s_ready=0 in WAIT_SETUP, LEAD, LOAD and DRAIN.
- cfg_busy = pending | (state in {LEAD, LOAD, DRAIN}).
- Bank writes:
  - Accepted in any state except LEAD and LOAD. Written at the clock edge.
  - A write in the same cycle as a LOAD read of the same address reads the old value. This cannot occur, because LOAD writes are rejected.
  - A write during LEAD or LOAD is dropped and cfg_wr_err pulses in the next cycle.
  - A write with cfg_addr >= NUM_WORDS is dropped and cfg_wr_err pulses.
- Commit rules:
  - A commit while pending=1 is coalesced (no queueing).
  - A commit during LEAD, LOAD or DRAIN sets pending. One additional burst follows after DRAIN, entered via PASS for exactly one cycle with s_ready=0.
  - Simultaneous cfg_we and cfg_commit in PASS: the write lands first, and the burst uses the new word.
- Reset mid-burst: return to WAIT_SETUP immediately at the reset edge. fir_set_coeffs drops in the cycle after reset is sampled. The partial load is abandoned and no cfg_done is issued.
- No arithmetic beyond counters. Counters saturate or wrap only at their terminal values as stated above.

Test Plan:
- Reset release, s_valid=1 held: s_ready=0 for 4 cycles, then s_ready=1 and fir_tvalid=1 from cycle 5, with fir_x_n tracking s_data.
- Write words 0..6 = 6'h01..6'h07, then commit in PASS:
  - Cycle after commit: s_ready=0 and fir_set_coeffs=1.
  - The next 7 cycles show fir_x_n = 8'h01..8'h07.
  - Then 2 drain cycles, with cfg_done on the 2nd.
  - s_ready=1 on the following cycle; cfg_busy high throughout.
- Write to addr 3 during LOAD: cfg_wr_err pulses 1 cycle later; a re-commit shows the original word at addr 3.
- Commit pulsed twice during LOAD: exactly one extra burst follows, with one PASS cycle of s_ready=0 between the bursts. Total cfg_done count = 2.
- Reset asserted at LOAD idx=4:
  - Next cycle fir_set_coeffs=0 and state is WAIT_SETUP.
  - No cfg_done is issued, and samples resume after 4 cycles.
- Write to addr 7 (NUM_WORDS=7): cfg_wr_err pulses, and no bank word changes.

Source files
------------

// File: rtl/fir_coef_sequencer_if.sv
// Bundles the configuration port, the upstream sample stream and the FIR-facing
// bus of the coefficient sequencer.
//   master : configuration/sample source (drives cfg_*, s_valid, s_data)
//   slave  : the sequencer (drives status, s_ready and the FIR x_n bus)
interface fir_coef_sequencer_if #(
    parameter int X_N_SIZE = 8,
    parameter int ADDR_W   = 3
);
    logic                cfg_we;
    logic [ADDR_W-1:0]   cfg_addr;
    logic [5:0]          cfg_wdata;
    logic                cfg_commit;
    logic                cfg_busy;
    logic                cfg_done;
    logic                cfg_wr_err;
    logic                s_valid;
    logic [X_N_SIZE-1:0] s_data;
    logic                s_ready;
    logic [X_N_SIZE-1:0] fir_x_n;
    logic                fir_tvalid;
    logic                fir_set_coeffs;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, cfg_commit, s_valid, s_data,
        input  cfg_busy, cfg_done, cfg_wr_err, s_ready, fir_x_n, fir_tvalid, fir_set_coeffs
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, cfg_commit, s_valid, s_data,
        output cfg_busy, cfg_done, cfg_wr_err, s_ready, fir_x_n, fir_tvalid, fir_set_coeffs
    );
endinterface

// File: rtl/fir_coef_sequencer.sv
// Owns the shared FIR x_n bus: holds one coefficient image in a small bank and
// sequences the post-reset setup window, coefficient reload bursts and the
// sample stream so that the two kinds of traffic never overlap.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active high
//   bus   : configuration, sample stream and FIR bus (slave modport)
//
// state      | meaning
// WAIT_SETUP | FIR setup window after reset, no traffic
// PASS       | samples forwarded to the FIR unless a reload is pending
// LEAD       | set_coeffs raised ahead of the first coefficient word
// LOAD       | one bank word per cycle onto x_n
// DRAIN      | quiet gap after a burst; cfg_done on its last cycle
module fir_coef_sequencer #(
    parameter int X_N_SIZE     = 8,
    parameter int NUM_WORDS    = 7,
    parameter int ADDR_W       = 3,
    parameter int SETUP_CYCLES = 4,
    parameter int LEAD_CYCLES  = 1,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    fir_coef_sequencer_if.slave  bus
);

    localparam logic [2:0] WAIT_SETUP = 3'd0;
    localparam logic [2:0] PASS       = 3'd1;
    localparam logic [2:0] LEAD       = 3'd2;
    localparam logic [2:0] LOAD       = 3'd3;
    localparam logic [2:0] DRAIN      = 3'd4;

    // One counter serves every timed state; it also indexes the bank in LOAD,
    // so it must reach the full address range.
    localparam int MAX_AB  = (SETUP_CYCLES > LEAD_CYCLES) ? SETUP_CYCLES : LEAD_CYCLES;
    localparam int MAX_CD  = (DRAIN_CYCLES > (1 << ADDR_W)) ? DRAIN_CYCLES : (1 << ADDR_W);
    localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(MAX_ALL + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] LEAD_LAST  = CNT_W'(LEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic             wr_err_q, wr_err_d;
    logic [5:0]       bank_q [NUM_WORDS];

    logic             in_load_window;
    logic             addr_ok;
    logic             wr_ok;
    logic [5:0]       load_word;

    assign in_load_window = (state_q == LEAD) || (state_q == LOAD);
    assign addr_ok        = (32'(bus.cfg_addr) < 32'(NUM_WORDS));
    assign wr_ok          = bus.cfg_we && addr_ok && !in_load_window;
    assign wr_err_d       = bus.cfg_we && (!addr_ok || in_load_window);
    assign load_word      = bank_q[cnt_q[ADDR_W-1:0]];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q | bus.cfg_commit;
        case (state_q)
            WAIT_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = PASS;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PASS: begin
                // A commit arriving in PASS starts the burst directly; a latched
                // one costs a single blocked PASS cycle first.
                if (pending_q || bus.cfg_commit) begin
                    state_d   = LEAD;
                    cnt_d     = '0;
                    pending_d = 1'b0;
                end
            end
            LEAD: begin
                if (cnt_q == LEAD_LAST) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LOAD: begin
                if (cnt_q == LOAD_LAST) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = PASS;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = WAIT_SETUP;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= WAIT_SETUP;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            wr_err_q  <= wr_err_d;
        end
    end

    // Bank contents survive reset on purpose; software reloads them.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            bank_q[bus.cfg_addr] <= bus.cfg_wdata;
        end
    end

    assign bus.s_ready        = (state_q == PASS) && !pending_q;
    assign bus.fir_tvalid     = bus.s_valid && bus.s_ready;
    assign bus.fir_set_coeffs = in_load_window;
    assign bus.fir_x_n        = (state_q == LOAD) ? {{(X_N_SIZE-6){1'b0}}, load_word} :
                                bus.s_ready       ? bus.s_data : '0;
    assign bus.cfg_busy       = pending_q || in_load_window || (state_q == DRAIN);
    assign bus.cfg_done       = (state_q == DRAIN) && (cnt_q == DRAIN_LAST);
    assign bus.cfg_wr_err     = wr_err_q;

endmodule

// File: tb/tb_fir_coef_sequencer.sv
module tb_fir_coef_sequencer;

    localparam int XN  = 8;
    localparam int NW  = 7;
    localparam int AW  = 3;
    localparam int SC  = 4;
    localparam int LC  = 1;
    localparam int DC  = 2;
    localparam int TOT = LC + NW + DC;

    typedef logic [NW-1:0][5:0] img_t;

    logic clk;
    logic reset;

    fir_coef_sequencer_if #(.X_N_SIZE(XN), .ADDR_W(AW)) bus_if ();

    fir_coef_sequencer #(
        .X_N_SIZE(XN), .NUM_WORDS(NW), .ADDR_W(AW),
        .SETUP_CYCLES(SC), .LEAD_CYCLES(LC), .DRAIN_CYCLES(DC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_seen = 0;
    int   done_exp  = 0;
    img_t model_bank;
    img_t burst_q[$];
    logic [XN-1:0] sample_q[$];
    logic acc = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Upstream sample source: holds each sample until it is taken.
    always @(negedge clk) acc = bus_if.s_valid && bus_if.s_ready && !reset;

    always @(posedge clk) begin
        #1;
        if (acc) bus_if.s_valid = 1'b0;
        if (!bus_if.s_valid && $urandom_range(0, 3) != 0) begin
            bus_if.s_data  = 8'($urandom);
            bus_if.s_valid = 1'b1;
            sample_q.push_back(bus_if.s_data);
        end
    end

    // Monitor: sample data, burst content/length and cfg_done placement.
    int run_len = 0;
    bit in_run  = 1'b0;
    int cd      = 0;
    logic [NW-1:0][7:0] got;

    always @(negedge clk) begin
        if (reset) begin
            in_run  = 1'b0;
            run_len = 0;
            cd      = 0;
        end else begin
            if (bus_if.fir_tvalid) begin
                if (sample_q.size() == 0) begin
                    chk("sample_unexpected", 32'(bus_if.fir_x_n), 32'hFFFF_FFFF);
                end else begin
                    chk("sample_data", 32'(bus_if.fir_x_n), 32'(sample_q.pop_front()));
                end
            end
            if (bus_if.fir_set_coeffs) begin
                chk("busy_in_burst", 32'(bus_if.cfg_busy), 32'd1);
                if (run_len < LC) chk("lead_x_n", 32'(bus_if.fir_x_n), 32'd0);
                else if (run_len < LC + NW) got[run_len - LC] = bus_if.fir_x_n;
                run_len++;
                in_run = 1'b1;
            end else if (in_run) begin
                in_run = 1'b0;
                chk("burst_len", 32'(run_len), 32'(LC + NW));
                if (burst_q.size() == 0) begin
                    chk("burst_unexpected", 32'(run_len), 32'd0);
                end else begin
                    img_t img;
                    img = burst_q.pop_front();
                    for (int w = 0; w < NW; w++)
                        chk("coef_word", 32'(got[w]), 32'({2'b00, img[w]}));
                end
                run_len = 0;
                cd = DC;
            end
            if (bus_if.cfg_done) done_seen++;
            if (cd > 0) begin
                chk("cfg_done_timing", 32'(bus_if.cfg_done), 32'(cd == 1));
                cd--;
            end else if (bus_if.cfg_done) begin
                chk("cfg_done_unexpected", 32'(bus_if.cfg_done), 32'd0);
            end
        end
    end

    // First cycle after the reset edge: SC blocked cycles, then samples flow.
    task automatic check_setup(input bit chk_tv);
        for (int k = 1; k <= SC + 1; k++) begin
            @(negedge clk);
            chk("setup_ready", 32'(bus_if.s_ready), 32'(k == SC + 1));
            chk("setup_set_coeffs", 32'(bus_if.fir_set_coeffs), 32'd0);
            chk("setup_busy", 32'(bus_if.cfg_busy), 32'd0);
            if (chk_tv && k == SC + 1) begin
                chk("first_tvalid", 32'(bus_if.fir_tvalid), 32'd1);
                chk("first_x_n", 32'(bus_if.fir_x_n), 32'hA5);
            end
            next();
        end
    endtask

    // Write one word in PASS; the error flag is checked on the following cycle.
    task automatic cfg_write(input int addr, input logic [5:0] data);
        bus_if.cfg_we    = 1'b1;
        bus_if.cfg_addr  = AW'(addr);
        bus_if.cfg_wdata = data;
        if (addr < NW) model_bank[addr] = data;
        next();
        bus_if.cfg_we = 1'b0;
        @(negedge clk);
        chk("wr_err_pass", 32'(bus_if.cfg_wr_err), 32'(addr >= NW));
        next();
    endtask

    // k=0 is the commit cycle (when do_c); k=1 is the first set_coeffs cycle.
    // wr_k: write addr 3 in that cycle (must land in LEAD/LOAD, so rejected).
    // c2_k/c2b_k: extra commits during the burst. rst_k: reset in that cycle.
    task automatic run_burst(input bit do_c, input bit c_we, input int c_addr,
                             input logic [5:0] c_data, input int wr_k,
                             input int c2_k, input int c2b_k, input int rst_k);
        bit gap;
        gap = (c2_k >= 0) || (c2b_k >= 0);
        if (do_c) begin
            bus_if.cfg_commit = 1'b1;
            bus_if.cfg_we     = c_we;
            bus_if.cfg_addr   = AW'(c_addr);
            bus_if.cfg_wdata  = c_data;
            if (c_we) model_bank[c_addr] = c_data;
            burst_q.push_back(model_bank);
            @(negedge clk);
            chk("commit_cycle_ready", 32'(bus_if.s_ready), 32'd1);
            next();
            bus_if.cfg_commit = 1'b0;
            bus_if.cfg_we     = 1'b0;
        end
        if (gap) burst_q.push_back(model_bank);
        for (int k = 1; k <= TOT + 1; k++) begin
            bus_if.cfg_we     = (k == wr_k);
            bus_if.cfg_addr   = 3'd3;
            bus_if.cfg_wdata  = 6'h3F;
            bus_if.cfg_commit = (k == c2_k) || (k == c2b_k);
            reset             = (k == rst_k);
            @(negedge clk);
            chk("tl_set_coeffs", 32'(bus_if.fir_set_coeffs), 32'(k <= LC + NW));
            chk("tl_busy", 32'(bus_if.cfg_busy), 32'((k <= TOT) || gap));
            chk("tl_ready", 32'(bus_if.s_ready), 32'((k == TOT + 1) && !gap));
            chk("tl_wr_err", 32'(bus_if.cfg_wr_err), 32'((wr_k >= 0) && (k == wr_k + 1)));
            next();
            if (k == rst_k) break;
        end
        bus_if.cfg_we     = 1'b0;
        bus_if.cfg_commit = 1'b0;
        if (rst_k >= 0) begin
            reset = 1'b0;
            void'(burst_q.pop_front());
        end else begin
            done_exp++;
        end
    endtask

    initial begin
        int d0;
        reset             = 1'b1;
        bus_if.cfg_we     = 1'b0;
        bus_if.cfg_addr   = '0;
        bus_if.cfg_wdata  = '0;
        bus_if.cfg_commit = 1'b0;
        bus_if.s_data     = 8'hA5;
        bus_if.s_valid    = 1'b1;
        sample_q.push_back(8'hA5);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_busy", 32'(bus_if.cfg_busy), 32'd0);
        chk("reset_done", 32'(bus_if.cfg_done), 32'd0);
        chk("reset_set_coeffs", 32'(bus_if.fir_set_coeffs), 32'd0);
        chk("reset_x_n", 32'(bus_if.fir_x_n), 32'd0);
        next();
        reset = 1'b0;
        check_setup(1'b1);

        // Load 1..7 and reload.
        for (int i = 0; i < NW; i++) cfg_write(i, 6'(i + 1));
        run_burst(1'b1, 1'b0, 0, 6'h0, -1, -1, -1, -1);

        // Rejected write to addr 3 during LOAD, then a re-commit of the same image.
        run_burst(1'b1, 1'b0, 0, 6'h0, LC + 2, -1, -1, -1);
        run_burst(1'b1, 1'b0, 0, 6'h0, -1, -1, -1, -1);

        // Two commits during LOAD coalesce into one extra burst.
        d0 = done_seen;
        run_burst(1'b1, 1'b0, 0, 6'h0, -1, LC + 2, LC + 4, -1);
        run_burst(1'b0, 1'b0, 0, 6'h0, -1, -1, -1, -1);
        repeat (2) next();
        chk("coalesced_done_count", 32'(done_seen - d0), 32'd2);

        // Reset while LOAD presents word 4.
        d0 = done_seen;
        run_burst(1'b1, 1'b0, 0, 6'h0, -1, -1, -1, LC + 5);
        check_setup(1'b0);
        chk("abort_no_done", 32'(done_seen - d0), 32'd0);

        // Out-of-range address, then prove the bank is intact.
        cfg_write(NW, 6'h2A);
        run_burst(1'b1, 1'b0, 0, 6'h0, -1, -1, -1, -1);

        // Randomized writes, commits with simultaneous writes, mid-burst traffic.
        for (int it = 0; it < 12; it++) begin
            int nwr;
            int wr_k;
            int c2_k;
            nwr = $urandom_range(0, 4);
            for (int j = 0; j < nwr; j++) cfg_write($urandom_range(0, NW), 6'($urandom));
            repeat ($urandom_range(0, 3)) next();
            wr_k = ($urandom_range(0, 1) == 1) ? $urandom_range(1, LC + NW) : -1;
            c2_k = ($urandom_range(0, 1) == 1) ? $urandom_range(1, TOT) : -1;
            run_burst(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, NW - 1),
                      6'($urandom), wr_k, c2_k, -1, -1);
            if (c2_k >= 0) run_burst(1'b0, 1'b0, 0, 6'h0, -1, -1, -1, -1);
        end

        repeat (4) next();
        chk("bursts_outstanding", 32'(burst_q.size()), 32'd0);
        chk("done_total", 32'(done_seen), 32'(done_exp));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
